serial_addsub: RTL and testbench



---
 rtl/addsub_pkg.sv | 35 +++
 rtl/addsub_slice.sv | 31 +++
 rtl/serial_addsub.sv | 153 +++++++++++++++
 tb/tb_serial_addsub.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the serial adder/subtractor:
//   state_t      - FSM states IDLE / RUN / DONE
//   op_t         - operation select, OP_ADD = 0, OP_SUB = 1
//   calc_nslice  - number of slices in a WIDTH-bit operand
//   calc_cnt_w   - slice counter width ($clog2 of NSLICE, at least 1)
//   CNT_W        - counter width for the default 8-bit / 2-bit-slice build
// -----------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    function automatic int calc_nslice(input int width, input int slice);
        return width / slice;
    endfunction

    function automatic int calc_cnt_w(input int nslice);
        return ($clog2(nslice) < 1) ? 1 : $clog2(nslice);
    endfunction

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_SLICE = 2;
    localparam int CNT_W = calc_cnt_w(calc_nslice(DEFAULT_WIDTH, DEFAULT_SLICE));

endpackage

// File: rtl/addsub_slice.sv
// -----------------------------------------------------------------------------
// addsub_slice
// Combinational SLICE-bit adder reused every RUN cycle of serial_addsub.
// Ports:
//   a, b   [SLICE-1:0]  operand slices (b already inverted for subtraction)
//   cin                 carry into the slice
//   sum    [SLICE-1:0]  slice sum
//   cout                carry out of the slice
//   c_msb               carry into the slice's top bit (for signed overflow)
// -----------------------------------------------------------------------------
module addsub_slice #(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    assign sum   = total[SLICE-1:0];
    assign cout  = total[SLICE];
    // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out
    // of the top sum bit without a second, shorter adder.
    assign c_msb = sum[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];

endmodule

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
// Multi-cycle adder/subtractor: WIDTH-bit operands are processed SLICE bits
// per clock through a registered carry, reusing one addsub_slice.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds its data until then, and the block holds
// S / C_out / ovf stable while out_valid is high and out_ready is low.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake (in_ready high only in IDLE)
//   A, B, C_in, sub    operands; sub=0: A+B+C_in, sub=1: A-B-C_in
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   S, C_out, ovf      result, carry (1 = no borrow for sub), signed overflow
//   dbg_state          current FSM state
// Build option: define ADDSUB_SAT_EN to saturate S on signed overflow.
// -----------------------------------------------------------------------------
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             ovf,
    output state_t           dbg_state
);

    localparam int              NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int              CW     = calc_cnt_w(NSLICE);
    localparam logic [CW-1:0]   LAST   = CW'(NSLICE - 1);
`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;     // B, or ~B for subtraction
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    int               sl_base;
    logic [SLICE-1:0] sl_a, sl_b, sl_sum;
    logic             sl_cout, sl_cmsb;

    assign sl_base = int'(cnt_q) * SLICE;
    assign sl_a    = a_q[sl_base +: SLICE];
    assign sl_b    = b_q[sl_base +: SLICE];

    addsub_slice #(.SLICE(SLICE)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .cin   (carry_q),
        .sum   (sl_sum),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d = A;
                    // Subtraction is A + ~B + ~C_in (borrow-in inverted).
                    if (op_t'(sub) == OP_SUB) begin
                        b_d     = ~B;
                        carry_d = ~C_in;
                    end else begin
                        b_d     = B;
                        carry_d = C_in;
                    end
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[sl_base +: SLICE] = sl_sum;
                carry_d = sl_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    c_out_d = sl_cout;
                    ovf_d   = sl_cmsb ^ sl_cout;
`ifdef ADDSUB_SAT_EN
                    // Result sign follows A's sign whenever overflow occurs.
                    if (sl_cmsb ^ sl_cout) begin
                        s_d = a_q[WIDTH-1] ? SAT_NEG : SAT_POS;
                    end
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign C_out     = c_out_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
// Directed, table-driven bench for serial_addsub (WIDTH=8, SLICE=2), plus
// hand-written backpressure and mid-operation reset sequences.
// Honours ADDSUB_SAT_EN when selecting expected S on overflow.
// -----------------------------------------------------------------------------
module tb_serial_addsub;
    import addsub_pkg::*;

    localparam int W      = 8;
    localparam int SL     = 2;
    localparam int NSLICE = W / SL;
`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         c_in = 1'b0;
    logic         sub_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s_out;
    logic         c_out;
    logic         ovf_out;
    state_t       dbg_state;

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(W), .SLICE(SL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a_in),
        .B         (b_in),
        .C_in      (c_in),
        .sub       (sub_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s_out),
        .C_out     (c_out),
        .ovf       (ovf_out),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Present operands on a falling edge, hold in_valid over one rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sb);
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        c_in     = cin;
        sub_in   = sb;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts rising edges from the accepting edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sb;
        logic [W-1:0] s;
        logic [W-1:0] s_sat;
        logic         c;
        logic         v;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int lat;
        logic [W-1:0] exp_s;

        vecs[0]  = '{8'd100, 8'd27,  1'b0, 1'b0, 8'h7F, 8'h7F, 1'b0, 1'b0};
        vecs[1]  = '{8'd100, 8'd28,  1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
        vecs[2]  = '{8'd5,   8'd7,   1'b0, 1'b1, 8'hFE, 8'hFE, 1'b0, 1'b0};
        vecs[3]  = '{8'd7,   8'd5,   1'b1, 1'b1, 8'h01, 8'h01, 1'b1, 1'b0};
        vecs[4]  = '{8'hFF,  8'h01,  1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{8'h80,  8'h80,  1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
        vecs[6]  = '{8'h7F,  8'h00,  1'b1, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
        vecs[7]  = '{8'h80,  8'h01,  1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
        vecs[8]  = '{8'h00,  8'h00,  1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0};
        vecs[9]  = '{8'h3C,  8'h5A,  1'b1, 1'b0, 8'h97, 8'h7F, 1'b0, 1'b1};
        vecs[10] = '{8'hAA,  8'h55,  1'b0, 1'b1, 8'h55, 8'h80, 1'b1, 1'b1};
        vecs[11] = '{8'h12,  8'h34,  1'b0, 1'b0, 8'h46, 8'h46, 1'b0, 1'b0};

        // ---------------- reset ----------------
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s",         32'(s_out),     32'd0);
        check("rst_c_out",     32'(c_out),     32'd0);
        check("rst_ovf",       32'(ovf_out),   32'd0);
        check("rst_state",     32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb);
            check("run_in_ready", 32'(in_ready), 32'd0);
            wait_valid(lat);
            exp_s = (SAT && vecs[i].v) ? vecs[i].s_sat : vecs[i].s;
            check($sformatf("v%0d_latency", i), 32'(lat),     32'(NSLICE + 1));
            check($sformatf("v%0d_s", i),       32'(s_out),   32'(exp_s));
            check($sformatf("v%0d_c_out", i),   32'(c_out),   32'(vecs[i].c));
            check($sformatf("v%0d_ovf", i),     32'(ovf_out), 32'(vecs[i].v));
            check($sformatf("v%0d_done_in_ready", i), 32'(in_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_back_idle", i), 32'(in_ready),  32'd1);
            check($sformatf("v%0d_valid_drop", i), 32'(out_valid), 32'd0);
        end

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        issue(8'd100, 8'd27, 1'b0, 1'b0);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'(NSLICE + 1));
        a_in     = 8'd1;
        b_in     = 8'd1;
        sub_in   = 1'b0;
        c_in     = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_s_stable",  32'(s_out),     32'h7F);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready),  32'd1);
        check("bp_release_valid",    32'(out_valid), 32'd0);
        check("bp_not_accepted_s",   32'(s_out),     32'h7F);
        @(posedge clk);
        @(negedge clk);
        check("bp_still_idle", 32'(dbg_state), 32'(IDLE));

        // ---------------- reset during RUN ----------------
        issue(8'h55, 8'h11, 1'b0, 1'b0);
        @(posedge clk);     // now in the second RUN cycle, one slice written
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",    32'(out_valid), 32'd0);
        check("mid_rst_s",        32'(s_out),     32'd0);
        check("mid_rst_in_ready", 32'(in_ready),  32'd1);
        check("mid_rst_state",    32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'd1, 8'd1, 1'b0, 1'b0);
        wait_valid(lat);
        check("post_rst_latency", 32'(lat),     32'(NSLICE + 1));
        check("post_rst_s",       32'(s_out),   32'd2);
        check("post_rst_c_out",   32'(c_out),   32'd0);
        check("post_rst_ovf",     32'(ovf_out), 32'd0);
        @(posedge clk);
        @(negedge clk);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
